cmd_assembler: RTL and testbench
================================

# cmd_assembler

Slave-side command framer on the far end of the UART link that carries 16-bit commands as two bytes, high byte first. It consumes bytes from a UART receiver and rebuilds the 16-bit command for the command-processing logic. It aborts a half-received command after an inter-byte timeout. It also hands single response bytes back to the UART transmitter and reports their completion.

## Interface
- TIMEOUT, 131072, max clock cycles allowed between the high and low byte; counter width is $clog2(TIMEOUT)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from UART
- rx_rdy  input  1  UART byte-valid; stays high until cleared via clr_rx_rdy
- clr_rx_rdy  output  1  combinational one-cycle acknowledge to UART; UART drops rx_rdy on the edge where this is sampled high
- cmd  output  16  assembled command {high, low}; holds until next completed command
- cmd_rdy  output  1  sticky command-valid flag
- clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
- err_timeout  output  1  registered one-cycle pulse, partial command discarded
- resp  input  8  response byte to send
- send_resp  input  1  request to transmit resp
- trmt  output  1  registered one-cycle start strobe to UART transmitter
- tx_data  output  8  registered byte to UART transmitter
- tx_done  input  1  UART transmit-complete
- resp_sent  output  1  registered one-cycle pulse, response byte finished

## Operation
- Reset: RX FSM in WAIT_HIGH, TX FSM in TX_IDLE. cmd, high-byte register, timer and tx_data reset to 0. cmd_rdy, err_timeout, trmt and resp_sent reset to 0. clr_rx_rdy is 0 while rst_n is low.
- RX FSM, WAIT_HIGH:
  - On rx_rdy: capture rx_data into the high register, assert clr_rx_rdy that cycle, clear cmd_rdy, zero the timer, go to WAIT_LOW.
- RX FSM, WAIT_LOW:
  - The timer increments every cycle.
  - On rx_rdy: cmd <= {high, rx_data}, set cmd_rdy, assert clr_rx_rdy, go to WAIT_HIGH.
  - Else if timer == TIMEOUT-1: pulse err_timeout, discard the high byte, go to WAIT_HIGH. cmd and cmd_rdy are unchanged.
- Simultaneous events:
  - rx_rdy in the timeout cycle: the byte is accepted and no error is raised.
  - clr_cmd_rdy in the same cycle cmd_rdy is set: set wins.
  - clr_cmd_rdy while in WAIT_LOW: clears normally.
- clr_rx_rdy is never asserted without rx_rdy high in an accepting state.
- TX FSM, TX_IDLE:
  - On send_resp: tx_data <= resp, trmt <= 1 for exactly one cycle, go to TX_BUSY.
- TX FSM, TX_BUSY:
  - send_resp is ignored and resp is not captured.
  - On tx_done: pulse resp_sent, go to TX_IDLE.
- The RX and TX FSMs are fully independent; both may be active in the same cycle.
- Reset mid-operation: a partial high byte is lost, an in-flight response is abandoned, and all outputs return to their reset values immediately (async).

## Timing
- clr_rx_rdy is combinational, in the same cycle rx_rdy is seen.
- cmd and cmd_rdy update on the edge that accepts the low byte, so they are visible 1 cycle after rx_rdy.
- cmd_rdy falls on the edge accepting a new high byte, or on the edge after clr_cmd_rdy.
- Timeout: err_timeout is high in the cycle after TIMEOUT cycles spent in WAIT_LOW with no rx_rdy.
- trmt and tx_data are valid the cycle after send_resp; trmt is never high for 2 consecutive cycles.
- resp_sent is high the cycle after tx_done.
- The earliest next send_resp is accepted is in the cycle resp_sent is high (FSM already in TX_IDLE).
- Throughput: back-to-back bytes are accepted on consecutive rx_rdy cycles with no bubble requirement.

## Test plan
- Bytes 0xA5 then 0x5A, each as rx_rdy with a one-cycle clr handshake -> cmd=16'hA55A and cmd_rdy=1 one cycle after the second rx_rdy. clr_rx_rdy pulses exactly twice.
- After a completed 0x1234, drive clr_cmd_rdy -> cmd_rdy=0 and cmd stays 0x1234. Then send 0xBE, 0xEF -> cmd_rdy drops at 0xBE and reasserts with cmd=0xBEEF.
- TIMEOUT=16: send 0x77, then no byte for 16 cycles -> single err_timeout pulse and cmd unchanged. Then 0x12, 0x34 -> cmd=0x1234 (0x77 not used).
- TIMEOUT=16: second byte arrives exactly in the timeout cycle -> no err_timeout and the command completes.
- send_resp with resp=0x3C -> trmt one cycle with tx_data=0x3C. A second send_resp with 0xFF while busy is ignored (tx_data stays 0x3C). tx_done -> resp_sent one cycle.
- Assert rst_n low after the high byte and during TX_BUSY -> all outputs 0. After release, a fresh 0x00/0x01 pair yields cmd=0x0001.

Source files
------------

// File: rtl/cmd_assembler.sv
// cmd_assembler: rebuilds 16-bit commands from two UART bytes (high byte
// first), drops a half-received command after an inter-byte timeout, and
// hands single response bytes to the UART transmitter.
module cmd_assembler #(
    parameter int TIMEOUT = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        err_timeout,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent
);

    localparam int              TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic { WAIT_HIGH, WAIT_LOW } rx_state_t;
    typedef enum logic { TX_IDLE,   TX_BUSY  } tx_state_t;

    rx_state_t       rx_state_q,    rx_state_d;
    logic [7:0]      high_q,        high_d;
    logic [TW-1:0]   timer_q,       timer_d;
    logic [15:0]     cmd_q,         cmd_d;
    logic            cmd_rdy_q,     cmd_rdy_d;
    logic            err_timeout_q, err_timeout_d;

    tx_state_t       tx_state_q,    tx_state_d;
    logic [7:0]      tx_data_q,     tx_data_d;
    logic            trmt_q,        trmt_d;
    logic            resp_sent_q,   resp_sent_d;

    // Both RX states accept a byte, so the acknowledge simply follows rx_rdy;
    // gating with rst_n keeps it quiet while the block is held in reset.
    assign clr_rx_rdy = rx_rdy & rst_n;

    // RX next-state: byte capture, command completion, inter-byte timeout.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rx_state_d    = rx_state_q;
        high_d        = high_q;
        timer_d       = timer_q;
        cmd_d         = cmd_q;
        cmd_rdy_d     = cmd_rdy_q;
        err_timeout_d = 1'b0;

        // Consumer acknowledge; a completing low byte below overrides it.
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        case (rx_state_q)
            WAIT_HIGH: begin
                if (rx_rdy) begin
                    high_d     = rx_data;
                    cmd_rdy_d  = 1'b0;
                    timer_d    = '0;
                    rx_state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                timer_d = timer_q + TW'(1);
                if (rx_rdy) begin
                    // A byte in the timeout cycle still completes the command.
                    cmd_d      = {high_q, rx_data};
                    cmd_rdy_d  = 1'b1;
                    rx_state_d = WAIT_HIGH;
                end else if (timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    high_d        = '0;
                    rx_state_d    = WAIT_HIGH;
                end
            end
            default: rx_state_d = WAIT_HIGH;
        endcase
    end

    // TX next-state: latch one response byte, strobe trmt, wait for tx_done.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d  = resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // State registers for both FSMs and their registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= WAIT_HIGH;
            high_q        <= '0;
            timer_q       <= '0;
            cmd_q         <= '0;
            cmd_rdy_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_data_q     <= '0;
            trmt_q        <= 1'b0;
            resp_sent_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            rx_state_q    <= rx_state_d;
            high_q        <= high_d;
            timer_q       <= timer_d;
            cmd_q         <= cmd_d;
            cmd_rdy_q     <= cmd_rdy_d;
            err_timeout_q <= err_timeout_d;
            tx_state_q    <= tx_state_d;
            tx_data_q     <= tx_data_d;
            trmt_q        <= trmt_d;
            resp_sent_q   <= resp_sent_d;
        end
    end

    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign err_timeout = err_timeout_q;
    assign tx_data     = tx_data_q;
    assign trmt        = trmt_q;
    assign resp_sent   = resp_sent_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// tb_cmd_assembler: directed, table-driven bench for cmd_assembler with a
// short inter-byte timeout so the timeout corners are reachable quickly.
module tb_cmd_assembler;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        err_timeout;
    logic [7:0]  resp;
    logic        send_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt  = 0;

    cmd_assembler #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .err_timeout (err_timeout),
        .resp        (resp),
        .send_resp   (send_resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    // Count acknowledge cycles seen by the UART side.
    always @(posedge clk) begin
        if (clr_rx_rdy) ack_cnt <= ack_cnt + 1;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        clr_with_lo;  // consumer ack in the completing cycle
        logic        clr_after;    // consumer ack one cycle after completion
        logic [15:0] exp_cmd;
        logic        exp_rdy;      // cmd_rdy right after completion
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART receiver model: rx_rdy held until the acknowledge is sampled.
    task automatic send_byte(input logic [7:0] b, input logic clr_same);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = clr_same;
        #1;
        check("clr_rx_rdy_with_rx_rdy", 32'(clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulse_at;
        int npulse;
        int ack0;

        vecs[0] = '{hi: 8'hA5, lo: 8'h5A, clr_with_lo: 1'b0, clr_after: 1'b0, exp_cmd: 16'hA55A, exp_rdy: 1'b1};
        vecs[1] = '{hi: 8'h12, lo: 8'h34, clr_with_lo: 1'b0, clr_after: 1'b1, exp_cmd: 16'h1234, exp_rdy: 1'b1};
        vecs[2] = '{hi: 8'hBE, lo: 8'hEF, clr_with_lo: 1'b0, clr_after: 1'b0, exp_cmd: 16'hBEEF, exp_rdy: 1'b1};
        vecs[3] = '{hi: 8'hFF, lo: 8'h00, clr_with_lo: 1'b1, clr_after: 1'b0, exp_cmd: 16'hFF00, exp_rdy: 1'b1};
        vecs[4] = '{hi: 8'h00, lo: 8'hFF, clr_with_lo: 1'b0, clr_after: 1'b1, exp_cmd: 16'h00FF, exp_rdy: 1'b1};

        rst_n = 1'b0; rx_data = '0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        resp = '0; send_resp = 1'b0; tx_done = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {cmd, cmd_rdy, err_timeout, trmt, tx_data, resp_sent, clr_rx_rdy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: complete pairs back to back, checking cmd_rdy drop at the
        // high byte, completion value, set-wins and consumer clear.
        for (int i = 0; i < 5; i++) begin
            logic [15:0] prev_cmd;
            prev_cmd = cmd;
            ack0     = ack_cnt;
            send_byte(vecs[i].hi, 1'b0);
            check($sformatf("v%0d_rdy_after_hi", i), 32'(cmd_rdy), 32'd0);
            check($sformatf("v%0d_cmd_held_hi", i), 32'(cmd), 32'(prev_cmd));
            send_byte(vecs[i].lo, vecs[i].clr_with_lo);
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_rdy", i), 32'(cmd_rdy), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("v%0d_ack_pulses", i), 32'(ack_cnt - ack0), 32'd2);
            check($sformatf("v%0d_rdy_sticky", i), 32'(cmd_rdy), 32'd1);
            if (vecs[i].clr_after) begin
                clr_cmd_rdy = 1'b1;
                tick();
                clr_cmd_rdy = 1'b0;
                check($sformatf("v%0d_rdy_cleared", i), 32'(cmd_rdy), 32'd0);
                check($sformatf("v%0d_cmd_kept", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            end
        end

        // Timeout: high byte then silence -> one err_timeout pulse exactly
        // TIMEOUT cycles later, cmd untouched.
        send_byte(8'h77, 1'b0);
        pulse_at = -1;
        npulse   = 0;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            tick();
            if (err_timeout) begin
                if (pulse_at < 0) pulse_at = c;
                npulse++;
            end
        end
        check("timeout_pulse_cycle", 32'(pulse_at), 32'(TIMEOUT));
        check("timeout_pulse_count", 32'(npulse), 32'd1);
        check("timeout_cmd_kept", 32'(cmd), 32'h00FF);
        check("timeout_rdy_kept", 32'(cmd_rdy), 32'd0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("after_timeout_cmd", 32'(cmd), 32'h1234);

        // Low byte lands exactly in the timeout cycle: accepted, no error.
        send_byte(8'hC3, 1'b0);
        repeat (TIMEOUT - 1) tick();
        check("edge_no_early_err", 32'(err_timeout), 32'd0);
        send_byte(8'h3C, 1'b0);
        check("edge_cmd", 32'(cmd), 32'hC33C);
        check("edge_rdy", 32'(cmd_rdy), 32'd1);
        npulse = 0;
        for (int c = 0; c < TIMEOUT + 2; c++) begin
            if (err_timeout) npulse++;
            tick();
        end
        check("edge_no_err", 32'(npulse), 32'd0);

        // TX: one-cycle trmt, busy ignores a second request, resp_sent pulse,
        // and a new request is taken in the resp_sent cycle.
        resp = 8'h3C; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("tx_trmt", 32'(trmt), 32'd1);
        check("tx_data", 32'(tx_data), 32'h3C);
        resp = 8'hFF; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("tx_trmt_single", 32'(trmt), 32'd0);
        check("tx_busy_ignored", 32'(tx_data), 32'h3C);
        tick();
        check("tx_no_retrigger", 32'(trmt), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("tx_resp_sent", 32'(resp_sent), 32'd1);
        resp = 8'hA1; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("tx_resp_sent_pulse", 32'(resp_sent), 32'd0);
        check("tx_back_to_back_trmt", 32'(trmt), 32'd1);
        check("tx_back_to_back_data", 32'(tx_data), 32'hA1);

        // Reset mid-operation: pending high byte and busy TX both abandoned.
        send_byte(8'h99, 1'b0);
        rx_rdy = 1'b1; rx_data = 8'h55;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {cmd, cmd_rdy, err_timeout, trmt, tx_data, resp_sent, clr_rx_rdy}, 32'd0);
        rx_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h00, 1'b0);
        check("post_reset_rdy_after_hi", 32'(cmd_rdy), 32'd0);
        send_byte(8'h01, 1'b0);
        check("post_reset_cmd", 32'(cmd), 32'h0001);
        check("post_reset_rdy", 32'(cmd_rdy), 32'd1);
        resp = 8'h5E; send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("post_reset_tx_idle", 32'(trmt), 32'd1);
        check("post_reset_tx_data", 32'(tx_data), 32'h5E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
